mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORDS, default 128, memory depth in 32-bit words; addresses at or above WORDS*4 are out of range.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, synchronous, active-low.
REQ-004 i_req, i_addr[31:0]  input  1/32  instruction-fetch read request and byte address.
REQ-005 i_gnt  output  1  fetch request accepted this cycle.
REQ-006 i_rvalid, i_rdata[31:0], i_err  output  1/32/1  fetch response, registered.
REQ-007 d_req, d_we, d_addr[31:0], d_wdata[31:0], d_be[3:0], d_lock  input  data-port request, write flag, address, write data, byte enables, lock hold.
REQ-008 d_gnt, d_rvalid, d_rdata[31:0], d_err  output  data-port accept and registered response.
REQ-009 mem_address[31:0], mem_write_data[31:0], mem_byte_enable[3:0], mem_write_enable, mem_nrst  output  shared single-port memory drive; mem_nrst ties to nrst.
REQ-010 mem_read_data[31:0]  input  combinational memory read data for mem_address.

Function
REQ-011 A request is accepted (gnt high) in the same cycle req is high and the port wins arbitration; at most one gnt per cycle.
REQ-012 Requester SHALL hold req and all payload stable while req high and gnt low; arbiter SHALL NOT depend on payload of a non-granted port.
REQ-013 Arbitration state machine: ARB and LOCK states.
REQ-014 ARB, one requester: that port wins.
REQ-015 ARB, both requesting: round-robin; winner is the port not granted on the most recent grant (last_gnt register, updated on every grant).
REQ-016 ARB to LOCK: on d_gnt with d_lock high.
REQ-017 LOCK: only data port may win; i_gnt held low; d_gnt follows d_req.
REQ-018 LOCK to ARB: first cycle d_lock low with no d_req, or on a d_gnt with d_lock low; that grant completes normally.
REQ-019 Memory drive is combinational from winner: mem_address = winning addr; mem_write_data = d_wdata; mem_byte_enable = d_be for data port, 4'b0000 for fetch.
REQ-020 mem_write_enable high only on the cycle of d_gnt with d_we high, address aligned and in range; otherwise low.
REQ-021 Error: addr[1:0] != 0 or addr >= WORDS*4 gives a granted access with err=1, rdata=0, no memory write.
REQ-022 Latency: response one cycle after gnt; on the next rising edge rvalid<=1, rdata<=mem_read_data (pre-write value for writes), err<=error flag; rvalid pulses exactly one cycle per grant.
REQ-023 Writes return rvalid as acknowledge; rdata carries the pre-write word.
REQ-024 Back-to-back: one grant per cycle sustained; alternating grants when both ports request continuously in ARB.
REQ-025 No grant when neither requests: mem_write_enable=0, mem_address=0, mem_byte_enable=0.

Reset
REQ-026 While nrst low at a rising edge: state<=ARB, last_gnt<=data (fetch wins first tie), all rvalid/err<=0, all rdata<=0.
REQ-027 While nrst low: i_gnt, d_gnt and mem_write_enable forced 0 combinationally; no memory write.
REQ-028 Reset mid-transaction: pending response dropped; no rvalid for a request granted in the cycle reset asserts.

Verification
REQ-029 Tie after reset: i_req=d_req=1 (i_addr=0x10, d_addr=0x20 read) -> cycle0 i_gnt, cycle1 d_gnt and i_rvalid with word 4, cycle2 d_rvalid with word 8.
REQ-030 Byte write: d_we=1, d_addr=0x8, d_be=4'b0010, d_wdata=0x0000AB00 over word 0x11223344 -> mem word 2 = 0x1122AB44; d_rvalid rdata=0x11223344; fetch of 0x8 next returns 0x1122AB44.
REQ-031 Misaligned/out-of-range: d_addr=0x6 write, then i_addr=WORDS*4 read -> each err=1, rdata=0, mem_write_enable never high, memory unchanged.
REQ-032 Lock: d_lock=1 with three consecutive d_req while i_req=1 -> i_gnt low all three cycles; i_gnt high first cycle after d_lock and d_req drop.
REQ-033 Reset mid-stream: nrst low in the cycle of a d_gnt write -> no write, no d_rvalid; after release tie goes to fetch port.
REQ-034 Continuous contention 20 cycles -> grants alternate exactly, 10 each, one rvalid per grant, never two gnt in one cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of mem_arbiter: instruction-fetch port and data port.
// master = requesters, slave = arbiter.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, d_lock,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, d_lock,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory: round-robin on ties,
// data-port lock for atomic sequences, registered one-cycle responses.
module mem_arbiter #(
  parameter int unsigned WORDS = 128
) (
  input  logic         clk,
  input  logic         nrst,
  mem_arbiter_if.slave bus,
  output logic [31:0]  mem_address,
  output logic [31:0]  mem_write_data,
  output logic [3:0]   mem_byte_enable,
  output logic         mem_write_enable,
  output logic         mem_nrst,
  input  logic [31:0]  mem_read_data
);

  localparam logic [32:0] LIMIT = 33'(WORDS) << 2;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;  // 1: most recent grant went to the data port
  logic   i_bad, d_bad;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  assign i_bad    = addr_bad(bus.i_addr);
  assign d_bad    = addr_bad(bus.d_addr);
  assign mem_nrst = nrst;

  always_comb begin
    bus.i_gnt = 1'b0;
    bus.d_gnt = 1'b0;
    state_d   = state_q;
    last_d_d  = last_d_q;

    unique case (state_q)
      StArb: begin
        if (bus.i_req && bus.d_req) begin
          bus.i_gnt = last_d_q;
          bus.d_gnt = !last_d_q;
        end else begin
          bus.i_gnt = bus.i_req;
          bus.d_gnt = bus.d_req;
        end
      end
      StLock:  bus.d_gnt = bus.d_req;
      default: ;
    endcase

    if (!nrst) begin
      bus.i_gnt = 1'b0;
      bus.d_gnt = 1'b0;
    end

    if (bus.i_gnt) last_d_d = 1'b0;
    if (bus.d_gnt) last_d_d = 1'b1;

    unique case (state_q)
      StArb:   if (bus.d_gnt && bus.d_lock) state_d = StLock;
      // A final unlocked grant completes normally; an idle unlocked cycle also releases.
      StLock:  if (!bus.d_lock && (bus.d_gnt || !bus.d_req)) state_d = StArb;
      default: ;
    endcase
  end

  always_comb begin
    mem_address      = '0;
    mem_byte_enable  = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = bus.d_wdata;
    if (bus.d_gnt) begin
      mem_address      = bus.d_addr;
      mem_byte_enable  = bus.d_be;
      mem_write_enable = bus.d_we && !d_bad;
    end else if (bus.i_gnt) begin
      mem_address = bus.i_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StArb;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // rdata captures the pre-write word; a grant in a reset cycle never happens.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bus.i_rvalid <= 1'b0;
      bus.i_err    <= 1'b0;
      bus.i_rdata  <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.d_rdata  <= '0;
    end else begin
      bus.i_rvalid <= bus.i_gnt;
      bus.i_err    <= bus.i_gnt && i_bad;
      if (bus.i_gnt) bus.i_rdata <= i_bad ? '0 : mem_read_data;
      bus.d_rvalid <= bus.d_gnt;
      bus.d_err    <= bus.d_gnt && d_bad;
      if (bus.d_gnt) bus.d_rdata <= d_bad ? '0 : mem_read_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked against
// a cycle-level reference of the grant rules and a shadow memory.
module tb_mem_arbiter;
  localparam int unsigned WORDS = 128;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam logic [31:0] LIMIT = 32'(WORDS * 4);

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_enable, mem_nrst;

  mem_arbiter #(.WORDS(WORDS)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .bus              (bus),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_byte_enable  (mem_byte_enable),
    .mem_write_enable (mem_write_enable),
    .mem_nrst         (mem_nrst),
    .mem_read_data    (mem_read_data)
  );

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  bit          init_done = 1'b0;

  int nchk  = 0;
  int nfail = 0;
  bit m_locked = 1'b0;
  bit m_last_d = 1'b1;
  bit s_igt, s_dgt, s_we;

  function automatic logic [31:0] init_word(input int k);
    if (k == 2) return 32'h1122_3344;  // seeded for the byte-write case
    return {16'hC0DE, 16'(k * 7)};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  always_comb begin
    mem_read_data = '0;
    if (mem_address < LIMIT) mem_read_data = mem[mem_address[AW+1:2]];
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < int'(WORDS); k++) mem[k] <= init_word(k);
      init_done <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_address[AW+1:2]] <= merge(mem[mem_address[AW+1:2]], mem_write_data,
                                        mem_byte_enable);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check combinational grant/drive, then the registered response.
  task automatic step();
    int          w;
    bit          ib, db, ev_i, ev_d, ee_i, ee_d;
    logic [31:0] ea, ed_i, ed_d;
    @(negedge clk);
    w = 0;
    if (nrst) begin
      if (m_locked) begin
        if (bus.d_req) w = 2;
      end else if (bus.i_req && bus.d_req) w = m_last_d ? 1 : 2;
      else if (bus.i_req) w = 1;
      else if (bus.d_req) w = 2;
    end
    ib = bad(bus.i_addr);
    db = bad(bus.d_addr);
    s_igt = bus.i_gnt;
    s_dgt = bus.d_gnt;
    s_we  = mem_write_enable;
    check_eq("i_gnt", 32'(bus.i_gnt), 32'(w == 1));
    check_eq("d_gnt", 32'(bus.d_gnt), 32'(w == 2));
    check_eq("mem_we", 32'(mem_write_enable), 32'(w == 2 && bus.d_we && !db));
    ea = (w == 1) ? bus.i_addr : (w == 2) ? bus.d_addr : '0;
    check_eq("mem_addr", mem_address, ea);
    check_eq("mem_be", 32'(mem_byte_enable), 32'((w == 2) ? bus.d_be : 4'd0));
    if (w == 2) check_eq("mem_wdata", mem_write_data, bus.d_wdata);
    ev_i = (w == 1);
    ee_i = ib;
    ed_i = ib ? '0 : ref_mem[bus.i_addr[AW+1:2]];
    ev_d = (w == 2);
    ee_d = db;
    ed_d = db ? '0 : ref_mem[bus.d_addr[AW+1:2]];
    @(posedge clk);
    if (!nrst) begin
      m_locked = 1'b0;
      m_last_d = 1'b1;
    end else if (w == 1) begin
      m_last_d = 1'b0;
    end else if (w == 2) begin
      m_last_d = 1'b1;
      m_locked = bus.d_lock;
      if (bus.d_we && !db)
        ref_mem[bus.d_addr[AW+1:2]] = merge(ref_mem[bus.d_addr[AW+1:2]], bus.d_wdata, bus.d_be);
    end else if (m_locked && !bus.d_lock) begin
      m_locked = 1'b0;
    end
    #1;
    check_eq("i_rvalid", 32'(bus.i_rvalid), 32'(ev_i));
    check_eq("d_rvalid", 32'(bus.d_rvalid), 32'(ev_d));
    if (ev_i) begin
      check_eq("i_rdata", bus.i_rdata, ed_i);
      check_eq("i_err", 32'(bus.i_err), 32'(ee_i));
    end
    if (ev_d) begin
      check_eq("d_rdata", bus.d_rdata, ed_d);
      check_eq("d_err", 32'(bus.d_err), 32'(ee_d));
    end
  endtask

  task automatic idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    bus.d_lock  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
      1:       return LIMIT + 32'($urandom_range(0, 63)) * 4;
      2:       return $urandom();
      default: return 32'($urandom_range(0, WORDS - 1)) * 4;
    endcase
  endfunction

  task automatic new_fetch();
    bus.i_req  = ($urandom_range(0, 3) != 0);
    bus.i_addr = rand_addr();
  endtask

  task automatic new_data();
    bus.d_req   = ($urandom_range(0, 3) != 0);
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = rand_addr();
    bus.d_wdata = $urandom();
    bus.d_be    = 4'($urandom_range(0, 15));
    bus.d_lock  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int          gi, gd, rv;
    bit          prev_i;
    int          nbad;
    logic [31:0] w1;

    for (int k = 0; k < int'(WORDS); k++) ref_mem[k] = init_word(k);
    idle();
    nrst = 1'b0;
    step();
    step();
    check_eq("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check_eq("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check_eq("rst_i_rdata", bus.i_rdata, 32'd0);
    check_eq("rst_d_rdata", bus.d_rdata, 32'd0);
    check_eq("rst_errs", 32'({bus.i_err, bus.d_err}), 32'd0);
    check_eq("rst_mem_nrst", 32'(mem_nrst), 32'd0);
    nrst = 1'b1;

    // Tie after reset: fetch first, then data.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h20;
    step();
    check_eq("tie_c0_i_gnt", 32'(s_igt), 32'd1);
    bus.i_req = 1'b0;
    step();
    check_eq("tie_c1_d_gnt", 32'(s_dgt), 32'd1);
    check_eq("tie_i_rdata", bus.i_rdata, init_word(4));
    bus.d_req = 1'b0;
    step();
    check_eq("tie_d_rdata", bus.d_rdata, init_word(8));

    // Byte-lane write, then fetch of the same word.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h8;
    bus.d_be    = 4'b0010;
    bus.d_wdata = 32'h0000_AB00;
    step();
    idle();
    check_eq("bw_d_rdata", bus.d_rdata, 32'h1122_3344);
    check_eq("bw_mem_word", mem[2], 32'h1122_AB44);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8;
    step();
    idle();
    check_eq("bw_fetch", bus.i_rdata, 32'h1122_AB44);

    // Misaligned write and out-of-range fetch.
    w1          = mem[1];
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h6;
    bus.d_be    = 4'hF;
    bus.d_wdata = 32'hDEAD_BEEF;
    step();
    idle();
    check_eq("mis_we", 32'(s_we), 32'd0);
    check_eq("mis_err", 32'(bus.d_err), 32'd1);
    check_eq("mis_rdata", bus.d_rdata, 32'd0);
    bus.i_req  = 1'b1;
    bus.i_addr = LIMIT;
    step();
    idle();
    check_eq("oor_err", 32'(bus.i_err), 32'd1);
    check_eq("oor_rdata", bus.i_rdata, 32'd0);
    check_eq("mis_mem_kept", mem[1], w1);

    // Lock: fetch starved for three locked data grants, released one cycle after drop.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      bus.d_req  = 1'b1;
      bus.d_lock = 1'b1;
      bus.d_addr = 32'h30 + 32'(k * 4);
      step();
      check_eq("lock_i_low", 32'(s_igt), 32'd0);
    end
    bus.d_req  = 1'b0;
    bus.d_lock = 1'b0;
    step();
    check_eq("unlock_c0_i_low", 32'(s_igt), 32'd0);
    step();
    check_eq("unlock_i_gnt", 32'(s_igt), 32'd1);
    idle();

    // Reset during a data write.
    nrst        = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h4;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'hC;
    bus.d_be    = 4'hF;
    bus.d_wdata = 32'hFFFF_FFFF;
    step();
    check_eq("rstw_d_gnt", 32'(s_dgt), 32'd0);
    check_eq("rstw_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check_eq("rstw_mem", mem[3], init_word(3));
    nrst = 1'b1;
    step();
    check_eq("rstw_tie_fetch", 32'(s_igt), 32'd1);
    bus.i_req = 1'b0;
    step();
    idle();

    // Continuous contention.
    gi = 0;
    gd = 0;
    rv = 0;
    prev_i = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      gi += int'(s_igt);
      gd += int'(s_dgt);
      rv += int'(bus.i_rvalid) + int'(bus.d_rvalid);
      if (k > 0) check_eq("alt", 32'(s_igt), 32'(!prev_i));
      prev_i = s_igt;
      if (s_igt) bus.i_addr = 32'($urandom_range(0, WORDS - 1)) * 4;
      if (s_dgt) bus.d_addr = 32'($urandom_range(0, WORDS - 1)) * 4;
    end
    check_eq("cont_fetch_cnt", 32'(gi), 32'd10);
    check_eq("cont_data_cnt", 32'(gd), 32'd10);
    check_eq("cont_rvalid_cnt", 32'(rv), 32'd20);
    idle();

    // Randomized traffic with occasional resets.
    new_fetch();
    new_data();
    for (int n = 0; n < 600; n++) begin
      nrst = ($urandom_range(0, 39) != 0);
      step();
      if (s_igt || !bus.i_req) new_fetch();
      if (s_dgt || !bus.d_req) new_data();
    end
    idle();
    nrst = 1'b1;
    step();
    step();
    nbad = 0;
    for (int k = 0; k < int'(WORDS); k++) if (mem[k] !== ref_mem[k]) nbad++;
    check_eq("mem_final", 32'(nbad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
